uart_baud_gen: RTL and testbench

Parametrised baud-rate tick generator for the UART TX and RX paths. Replaces the fixed-divisor bit-clock counter with a runtime-loadable divisor, an exact DIV-cycle bit period, and an end-of-bit strobe. It also adds an oversample tick stream with a sample index for the RX front end and a bit counter. It sits between the UART control logic, which drives `Count_Sig` and loads the divisor, and the TX shifter or RX sampler, which consume the ticks.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_gen_if.sv | 30 +++
 rtl/uart_os_tick.sv | 56 +++++
 rtl/uart_baud_gen.sv | 104 ++++++++++
 tb/tb_uart_baud_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART timing constants used by the TX and RX paths and the baud generator.
package uart_pkg;
  localparam int UART_CNT_W       = 16;
  localparam int UART_BITCNT_W    = 4;
  localparam int UART_DEFAULT_DIV = 434;  // 50 MHz / 115200
  localparam int UART_OS_LOG2     = 4;
  localparam int UART_OS          = 1 << UART_OS_LOG2;
  localparam int UART_DIV_MIN     = 2 * UART_OS;
endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/tick bundle between the UART control logic (master) and the baud generator (slave).
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int CNT_W    = UART_CNT_W,
  parameter int OS_LOG2  = UART_OS_LOG2,
  parameter int BITCNT_W = UART_BITCNT_W
);
  logic                Count_Sig;
  logic                Div_Load;
  logic [CNT_W-1:0]    Div_Value;
  logic                BPS_CLK;
  logic                Bit_End;
  logic                Os_Tick;
  logic [OS_LOG2-1:0]  Os_Idx;
  logic [BITCNT_W-1:0] Bit_Cnt;
  logic [CNT_W-1:0]    Div_Cur;
  logic                Div_Pending;
  logic                Div_Err;

  modport master (
    output Count_Sig, Div_Load, Div_Value,
    input  BPS_CLK, Bit_End, Os_Tick, Os_Idx, Bit_Cnt, Div_Cur, Div_Pending, Div_Err
  );

  modport slave (
    input  Count_Sig, Div_Load, Div_Value,
    output BPS_CLK, Bit_End, Os_Tick, Os_Idx, Bit_Cnt, Div_Cur, Div_Pending, Div_Err
  );
endinterface

// File: rtl/uart_os_tick.sv
// Oversample sub-period counter: issues up to OS ticks per bit, one every sub_len clocks.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CNT_W   = UART_CNT_W,
  parameter int OS_LOG2 = UART_OS_LOG2
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               run,
  input  logic               bit_wrap,
  input  logic [CNT_W-1:0]   sub_len,
  output logic               os_tick,
  output logic [OS_LOG2-1:0] os_idx
);
  localparam int OSN_W = OS_LOG2 + 1;
  localparam logic [OSN_W-1:0] OS_N = OSN_W'(1 << OS_LOG2);

  logic [CNT_W-1:0] sub_r, sub_nxt_s;
  logic [OSN_W-1:0] os_n_r, os_n_nxt_s;
  logic             sub_last_s;

  assign sub_last_s = (sub_r == (sub_len - CNT_W'(1)));
  assign os_tick    = run && sub_last_s && (os_n_r < OS_N);
  assign os_idx     = os_tick ? os_n_r[OS_LOG2-1:0] : {OS_LOG2{1'b0}};

  // Next-state for the sub-period position and the per-bit tick count.
  always_comb begin
    sub_nxt_s  = sub_r;
    os_n_nxt_s = os_n_r;
    if (!run || bit_wrap) begin
      sub_nxt_s  = {CNT_W{1'b0}};
      os_n_nxt_s = {OSN_W{1'b0}};
    end else if (sub_last_s) begin
      sub_nxt_s = {CNT_W{1'b0}};
      if (os_tick) begin
        os_n_nxt_s = os_n_r + OSN_W'(1);
      end else begin
        os_n_nxt_s = os_n_r;
      end
    end else begin
      sub_nxt_s = sub_r + CNT_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sub_r  <= {CNT_W{1'b0}};
      os_n_r <= {OSN_W{1'b0}};
    end else begin
      sub_r  <= sub_nxt_s;
      os_n_r <= os_n_nxt_s;
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: exact DIV-cycle bit period, mid/end-of-bit strobes, oversample
// ticks and a divisor shadow register that only changes on bit boundaries or while idle.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W       = UART_CNT_W,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int OS_LOG2     = UART_OS_LOG2,
  parameter int BITCNT_W    = UART_BITCNT_W
) (
  input logic            CLK,
  input logic            RST_n,
  uart_baud_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2 << OS_LOG2);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    bit_pos_r, bit_pos_nxt_s;
  logic [CNT_W-1:0]    div_cur_r, div_cur_nxt_s;
  logic [CNT_W-1:0]    pend_r, pend_nxt_s;
  logic                pending_r, pending_nxt_s;
  logic                div_err_r;
  logic [BITCNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic                run_s, bit_end_s, load_ok_s;
  logic [CNT_W-1:0]    sub_len_s;

  assign run_s     = bus.Count_Sig;
  assign bit_end_s = run_s && (bit_pos_r == (div_cur_r - CNT_W'(1)));
  assign sub_len_s = div_cur_r >> OS_LOG2;
  assign load_ok_s = bus.Div_Load && (bus.Div_Value >= DIV_MIN);

  assign bus.BPS_CLK     = run_s && (bit_pos_r == (div_cur_r >> 1));
  assign bus.Bit_End     = bit_end_s;
  assign bus.Bit_Cnt     = bit_cnt_r;
  assign bus.Div_Cur     = div_cur_r;
  assign bus.Div_Pending = pending_r;
  assign bus.Div_Err     = div_err_r;

  uart_os_tick #(
    .CNT_W   (CNT_W),
    .OS_LOG2 (OS_LOG2)
  ) u_os_tick (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .run      (run_s),
    .bit_wrap (bit_end_s),
    .sub_len  (sub_len_s),
    .os_tick  (bus.Os_Tick),
    .os_idx   (bus.Os_Idx)
  );

  // Bit position and completed-bit counter.
  always_comb begin
    bit_pos_nxt_s = bit_pos_r;
    bit_cnt_nxt_s = bit_cnt_r;
    if (!run_s) begin
      bit_pos_nxt_s = {CNT_W{1'b0}};
      bit_cnt_nxt_s = {BITCNT_W{1'b0}};
    end else if (bit_end_s) begin
      bit_pos_nxt_s = {CNT_W{1'b0}};
      bit_cnt_nxt_s = bit_cnt_r + BITCNT_W'(1);
    end else begin
      bit_pos_nxt_s = bit_pos_r + CNT_W'(1);
    end
  end

  // Divisor update: a new value only takes effect while idle or at a bit boundary.
  always_comb begin
    div_cur_nxt_s = div_cur_r;
    pend_nxt_s    = pend_r;
    pending_nxt_s = pending_r;
    if (load_ok_s && (!run_s || bit_end_s)) begin
      div_cur_nxt_s = bus.Div_Value;
      pending_nxt_s = 1'b0;
    end else if (load_ok_s) begin
      pend_nxt_s    = bus.Div_Value;
      pending_nxt_s = 1'b1;
    end else if (pending_r && (!run_s || bit_end_s)) begin
      div_cur_nxt_s = pend_r;
      pending_nxt_s = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // State registers; reset discards any pending divisor.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bit_pos_r <= {CNT_W{1'b0}};
      bit_cnt_r <= {BITCNT_W{1'b0}};
      div_cur_r <= DIV_RST;
      pend_r    <= {CNT_W{1'b0}};
      pending_r <= 1'b0;
      div_err_r <= 1'b0;
    end else begin
      bit_pos_r <= bit_pos_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      div_cur_r <= div_cur_nxt_s;
      pend_r    <= pend_nxt_s;
      pending_r <= pending_nxt_s;
      div_err_r <= bus.Div_Load && !load_ok_s;
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus random traffic against a
// cycle-index reference model.
module tb_uart_baud_gen;
  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Reference model: cycle index since run start, start cycle of current bit, divisor state.
  int   t_m, bs_m, d_m, pv_m, nbits_m;
  bit   pend_m, err_m;

  uart_baud_gen_if #(.CNT_W(16), .OS_LOG2(4), .BITCNT_W(4)) bus ();

  uart_baud_gen #(
    .CNT_W(16), .DEFAULT_DIV(434), .OS_LOG2(4), .BITCNT_W(4)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t_m = 0; bs_m = 0; d_m = 434; pv_m = 0; nbits_m = 0; pend_m = 1'b0; err_m = 1'b0;
  endtask

  // Compare every output against the model, mid-cycle.
  task automatic sample();
    int pos, sub, p1, k;
    bit e_bps, e_end, e_tick;
    @(negedge CLK);
    e_bps = 1'b0; e_end = 1'b0; e_tick = 1'b0; k = 0;
    if (bus.Count_Sig) begin
      pos    = t_m - bs_m;
      sub    = d_m / 16;
      p1     = pos + 1;
      k      = p1 / sub;
      e_bps  = (pos == d_m / 2);
      e_end  = (pos == d_m - 1);
      e_tick = (p1 % sub == 0) && (k >= 1) && (k <= 16);
    end
    chk("bps_clk", 32'(bus.BPS_CLK), 32'(e_bps));
    chk("bit_end", 32'(bus.Bit_End), 32'(e_end));
    chk("os_tick", 32'(bus.Os_Tick), 32'(e_tick));
    if (e_tick) chk("os_idx", 32'(bus.Os_Idx), 32'(k - 1));
    chk("bit_cnt", 32'(bus.Bit_Cnt), 32'(nbits_m % 16));
    chk("div_cur", 32'(bus.Div_Cur), 32'(d_m));
    chk("div_pending", 32'(bus.Div_Pending), 32'(pend_m));
    chk("div_err", 32'(bus.Div_Err), 32'(err_m));
  endtask

  // Step the model with the current inputs, then move past the next rising edge.
  task automatic advance();
    bit cs, valid, endb;
    int val;
    cs    = bus.Count_Sig;
    val   = int'(bus.Div_Value);
    valid = bus.Div_Load && (val >= 32);
    endb  = cs && (t_m - bs_m == d_m - 1);
    if (!RST_n) begin
      model_reset();
    end else begin
      err_m = bus.Div_Load && !valid;
      if (valid && (!cs || endb)) begin
        d_m = val; pend_m = 1'b0;
      end else if (valid) begin
        pv_m = val; pend_m = 1'b1;
      end else if (pend_m && (!cs || endb)) begin
        d_m = pv_m; pend_m = 1'b0;
      end
      if (cs) begin
        if (endb) begin
          nbits_m++;
          bs_m = t_m + 1;
        end
        t_m++;
      end else begin
        t_m = 0; bs_m = 0; nbits_m = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit cs, input bit ld, input int val);
    bus.Count_Sig = cs;
    bus.Div_Load  = ld;
    bus.Div_Value = 16'(val);
  endtask

  initial begin
    bit cs_v;
    model_reset();
    drive(1'b0, 1'b0, 0);
    // Reset state
    sample();
    chk("rst_div_cur", 32'(bus.Div_Cur), 32'd434);
    advance();
    RST_n = 1'b1;
    advance();

    // Default divisor, three bits, with the oversample stream of bit 0
    for (int c = 0; c <= 1302; c++) begin
      drive(1'b1, 1'b0, 0);
      sample();
      if (c == 217 || c == 651 || c == 1085) chk("dflt_bps", 32'(bus.BPS_CLK), 32'd1);
      if (c == 433 || c == 867 || c == 1301) chk("dflt_bit_end", 32'(bus.Bit_End), 32'd1);
      if (c < 432 && (c + 1) % 27 == 0) begin
        chk("os_tick_b0", 32'(bus.Os_Tick), 32'd1);
        chk("os_idx_b0", 32'(bus.Os_Idx), 32'((c + 1) / 27 - 1));
      end
      if (c == 432 || c == 433) chk("os_leftover", 32'(bus.Os_Tick), 32'd0);
      if (c == 1302) chk("bit_cnt_3", 32'(bus.Bit_Cnt), 32'd3);
      advance();
    end

    // Load 100 while idle
    drive(1'b0, 1'b1, 100);
    sample();
    advance();
    drive(1'b0, 1'b0, 0);
    sample();
    chk("idle_load_div", 32'(bus.Div_Cur), 32'd100);
    chk("idle_load_pend", 32'(bus.Div_Pending), 32'd0);
    advance();
    for (int c = 0; c < 120; c++) begin
      drive(1'b1, 1'b0, 0);
      sample();
      if (c == 50) chk("d100_bps", 32'(bus.BPS_CLK), 32'd1);
      if (c == 99) chk("d100_bit_end", 32'(bus.Bit_End), 32'd1);
      advance();
    end

    // Restore 434, then load 200 mid-bit, reject 31, drop Count_Sig mid-bit
    drive(1'b0, 1'b1, 434);
    sample();
    advance();
    for (int c = 0; c <= 741; c++) begin
      drive(c <= 740 ? 1'b0 : 1'b0, 1'b0, 0);
      drive(c < 740, (c == 100) || (c == 710), (c == 710) ? 31 : 200);
      sample();
      if (c == 101) chk("mid_pending", 32'(bus.Div_Pending), 32'd1);
      if (c == 433) chk("mid_bit0_end", 32'(bus.Bit_End), 32'd1);
      if (c == 433) chk("mid_div_old", 32'(bus.Div_Cur), 32'd434);
      if (c == 434) chk("mid_div_new", 32'(bus.Div_Cur), 32'd200);
      if (c == 633) chk("mid_bit1_end", 32'(bus.Bit_End), 32'd1);
      if (c == 711) chk("rej_err", 32'(bus.Div_Err), 32'd1);
      if (c == 712) chk("rej_err_gone", 32'(bus.Div_Err), 32'd0);
      if (c == 712) chk("rej_div_cur", 32'(bus.Div_Cur), 32'd200);
      if (c == 740) chk("abort_no_end", 32'(bus.Bit_End), 32'd0);
      if (c == 741) chk("abort_bit_cnt", 32'(bus.Bit_Cnt), 32'd0);
      advance();
    end

    // Asynchronous reset with a divisor pending, mid-bit
    for (int c = 0; c < 50; c++) begin
      drive(1'b1, c == 10, 500);
      sample();
      advance();
    end
    RST_n = 1'b0;
    #1;
    chk("arst_div_cur", 32'(bus.Div_Cur), 32'd434);
    chk("arst_pending", 32'(bus.Div_Pending), 32'd0);
    chk("arst_bit_cnt", 32'(bus.Bit_Cnt), 32'd0);
    model_reset();
    drive(1'b0, 1'b0, 0);
    sample();
    advance();
    RST_n = 1'b1;
    advance();

    // Random traffic against the model
    cs_v = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 199) == 0) cs_v = !cs_v;
      drive(cs_v, $urandom_range(0, 39) == 0, int'($urandom_range(20, 300)));
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
